// File: rtl/final_flush_serializer_pkg.sv
// Shared definitions for the LP entropy encoder flush path: FSM states,
// rounding/shift biases and the word-count bound.
package entropy_encoder_lp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      FIN
   } flush_state_t;

   localparam int FLUSH_SHIFT_BIAS = 16;
   localparam int FLUSH_S_BIAS     = 10;
   localparam int FLUSH_STEP       = 8;

   // Largest number of words a flush can produce for a given count width.
   function automatic int flush_max_words(input int d_size);
      return ((1 << (d_size - 1)) - 1 + FLUSH_S_BIAS + FLUSH_STEP - 1) / FLUSH_STEP;
   endfunction

endpackage

// File: rtl/final_flush_serializer_if.sv
// Handshake bundle between the stage-4 source, the flush unit and the
// downstream carry-resolution buffer. FINAL_FLUSH_STATS_EN adds flush_words.
interface final_flush_serializer_if #(
   parameter int OUTPUT_BITSTREAM_WIDTH = 16,
   parameter int D_SIZE                 = 5,
   parameter int LOW_WIDTH              = 24
);
   logic                              in_valid;
   logic                              in_ready;
   logic [D_SIZE-1:0]                 in_cnt;
   logic [LOW_WIDTH-1:0]              in_low;
   logic                              out_valid;
   logic                              out_ready;
   logic [OUTPUT_BITSTREAM_WIDTH-1:0] out_word;
   logic                              out_last;
   logic                              done;
`ifdef FINAL_FLUSH_STATS_EN
   logic [7:0]                        flush_words;
`endif

   modport slave (
      input  in_valid, in_cnt, in_low, out_ready,
      output in_ready, out_valid, out_word, out_last, done
`ifdef FINAL_FLUSH_STATS_EN
      , output flush_words
`endif
   );

   modport master (
      output in_valid, in_cnt, in_low, out_ready,
      input  in_ready, out_valid, out_word, out_last, done
`ifdef FINAL_FLUSH_STATS_EN
      , input flush_words
`endif
   );

endinterface

// File: rtl/final_flush_serializer_round.sv
// OD_EC_ENC_DONE rounding of the final low value; result is one bit wider
// than low so the carry out of the mask add survives.
module flush_round_unit #(
   parameter int LOW_WIDTH = 24,
   parameter int MASK_BITS = 14
) (
   input  logic [LOW_WIDTH-1:0] low,
   output logic [LOW_WIDTH:0]   e
);
   localparam int EW = LOW_WIDTH + 1;
   localparam logic [EW-1:0] MASK      = EW'((64'd1 << MASK_BITS) - 64'd1);
   localparam logic [EW-1:0] MASK_NEXT = EW'(64'd1 << MASK_BITS);

   assign e = (({1'b0, low} + MASK) & ~MASK) | MASK_NEXT;

endmodule

// File: rtl/final_flush_serializer.sv
// End-of-stream flush: rounds the final low/cnt pair and streams the precarry
// words over valid/ready. Optional FINAL_FLUSH_STATS_EN adds flush_words.
//
// state | meaning
// IDLE  | in_ready high, waiting for the final low/cnt pair
// EMIT  | presenting precarry words, one per downstream handshake
// FIN   | done pulse, back to IDLE next cycle
module final_flush_serializer
   import entropy_encoder_lp_pkg::*;
#(
   parameter int OUTPUT_BITSTREAM_WIDTH = 16,
   parameter int D_SIZE                 = 5,
   parameter int LOW_WIDTH              = 24,
   parameter int MASK_BITS              = 14
) (
   input logic                    clk,
   input logic                    reset,
   final_flush_serializer_if.slave bus
);
   localparam int EW   = LOW_WIDTH + 1;
   localparam int SW   = D_SIZE + 2;
   localparam int OW   = OUTPUT_BITSTREAM_WIDTH;
   localparam int MAXW = flush_max_words(D_SIZE);
   localparam int WCW  = $clog2(MAXW + 1);

   flush_state_t   state;
   logic [EW-1:0]  e_q;
   logic [SW-1:0]  shift_q;
   logic [SW-1:0]  s_q;
   logic [WCW-1:0] words_left;
   logic           in_ready_q;
   logic           out_valid_q;
   logic [OW-1:0]  out_word_q;
   logic           out_last_q;
   logic           done_q;

   logic [EW-1:0]  e_rnd;
   logic [SW-1:0]  cnt_ext;
   logic [SW-1:0]  shift_init;
   logic [SW-1:0]  s_init;
   logic           s_init_pos;
   logic [WCW-1:0] words_init;
   logic [EW-1:0]  word_init_full;
   logic [EW-1:0]  e_nxt;
   logic [SW-1:0]  shift_nxt;
   logic [SW-1:0]  s_nxt;
   logic           s_nxt_pos;
   logic [EW-1:0]  word_nxt_full;

   flush_round_unit #(
      .LOW_WIDTH (LOW_WIDTH),
      .MASK_BITS (MASK_BITS)
   ) u_round (
      .low (bus.in_low),
      .e   (e_rnd)
   );

   // s and shift are signed; positivity is tested via the sign bit so the
   // rest of the datapath can stay unsigned.
   always_comb begin
      cnt_ext        = {{2{bus.in_cnt[D_SIZE-1]}}, bus.in_cnt};
      shift_init     = cnt_ext + SW'(FLUSH_SHIFT_BIAS);
      s_init         = cnt_ext + SW'(FLUSH_S_BIAS);
      s_init_pos     = !s_init[SW-1] && (s_init != '0);
      words_init     = WCW'((int'(s_init) + FLUSH_STEP - 1) / FLUSH_STEP);
      word_init_full = e_rnd >> shift_init;

      e_nxt          = e_q & ((EW'(1) << shift_q) - EW'(1));
      shift_nxt      = shift_q - SW'(FLUSH_STEP);
      s_nxt          = s_q - SW'(FLUSH_STEP);
      s_nxt_pos      = !s_nxt[SW-1] && (s_nxt != '0);
      word_nxt_full  = e_nxt >> shift_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         e_q         <= '0;
         shift_q     <= '0;
         s_q         <= '0;
         words_left  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  e_q        <= e_rnd;
                  shift_q    <= shift_init;
                  s_q        <= s_init;
                  in_ready_q <= 1'b0;
                  if (s_init_pos) begin
                     out_valid_q <= 1'b1;
                     out_word_q  <= OW'(word_init_full[8:0]);
                     out_last_q  <= (words_init == WCW'(1));
                     words_left  <= words_init;
                     state       <= EMIT;
                  end else begin
                     done_q <= 1'b1;
                     state  <= FIN;
                  end
               end
            end
            EMIT: begin
               if (bus.out_ready) begin
                  e_q        <= e_nxt;
                  shift_q    <= shift_nxt;
                  s_q        <= s_nxt;
                  words_left <= words_left - WCW'(1);
                  if (!s_nxt_pos) begin
                     out_valid_q <= 1'b0;
                     out_word_q  <= '0;
                     out_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                     state       <= FIN;
                  end else begin
                     out_word_q <= OW'(word_nxt_full[8:0]);
                     out_last_q <= (words_left == WCW'(2));
                  end
               end
            end
            FIN: begin
               done_q     <= 1'b0;
               in_ready_q <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_word  = out_word_q;
   assign bus.out_last  = out_last_q;
   assign bus.done      = done_q;

`ifdef FINAL_FLUSH_STATS_EN
   logic [7:0] stats_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stats_q <= '0;
      end else if (out_valid_q && bus.out_ready && (stats_q != 8'hFF)) begin
         stats_q <= stats_q + 8'd1;
      end
   end

   assign bus.flush_words = stats_q;
`endif

endmodule

// File: tb/tb_final_flush_serializer.sv
// Bench for final_flush_serializer: directed vector table, backpressure and
// mid-flush reset sequences, then randomized flushes against a word model.
module tb_final_flush_serializer;
   logic clk;
   logic reset;

   final_flush_serializer_if #(
      .OUTPUT_BITSTREAM_WIDTH (16),
      .D_SIZE                 (5),
      .LOW_WIDTH              (24)
   ) bus ();

   final_flush_serializer #(
      .OUTPUT_BITSTREAM_WIDTH (16),
      .D_SIZE                 (5),
      .LOW_WIDTH              (24),
      .MASK_BITS              (14)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int low;
      int n;
      int w0;
      int w1;
      int w2;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;
   int hs_total = 0;
   int exp_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word k is the 8-bit slice of the rounded value sitting at bit
   // (cnt+16-8k); the first word also carries the bit above it.
   function automatic void build_expected(input int cnt, input longint low);
      longint m;
      longint e;
      int     s;
      int     n;
      m = (64'd1 << 14) - 64'd1;
      e = ((low + m) & ~m) | (m + 64'd1);
      s = cnt + 10;
      n = 0;
      while (n * 8 < s) n++;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         if (k == 0) exp_q.push_back(int'((e >> (cnt + 16)) & 64'h1FF));
         else        exp_q.push_back(int'((e >> (cnt + 16 - 8 * k)) & 64'hFF));
      end
   endfunction

   task automatic run_flush(input int cnt, input int low, input int ready_pct,
                            input int stall_idx, input int stall_len);
      int idx;
      int stalled;
      int budget;
      bit rdy;
      idx = 0;
      stalled = 0;
      budget = 0;
      @(negedge clk);
      check("in_ready_idle", bus.in_ready, 1);
      bus.in_cnt   = 5'(cnt);
      bus.in_low   = 24'(low);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("in_ready_busy", bus.in_ready, 0);
      while (idx < exp_q.size() && budget < 100) begin
         check("out_valid", bus.out_valid, 1);
         check("done_early", bus.done, 0);
         check("out_word", bus.out_word, exp_q[idx]);
         check("out_last", bus.out_last, (idx == exp_q.size() - 1) ? 1 : 0);
         if (idx == stall_idx && stalled < stall_len) begin
            rdy = 1'b0;
            stalled++;
         end else begin
            rdy = ($urandom_range(99) < ready_pct);
         end
         bus.out_ready = rdy;
         @(negedge clk);
         if (rdy) begin
            idx++;
            hs_total++;
         end
         budget++;
      end
      if (budget >= 100) check("word_timeout", idx, exp_q.size());
      bus.out_ready = 1'b0;
      check("done_pulse", bus.done, 1);
      check("out_valid_fin", bus.out_valid, 0);
      check("in_ready_fin", bus.in_ready, 0);
      @(negedge clk);
      check("done_clear", bus.done, 0);
      check("in_ready_back", bus.in_ready, 1);
   endtask

   vec_t vecs[7];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{cnt: -9,  low: 'h001234, n: 1, w0: 'h080, w1: 0,      w2: 0};
      vecs[1] = '{cnt: 0,   low: 'h0ABCDE, n: 2, w0: 'h00A, w1: 'h0C0, w2: 0};
      vecs[2] = '{cnt: 0,   low: 'hFFD000, n: 2, w0: 'h100, w1: 'h040, w2: 0};
      vecs[3] = '{cnt: 7,   low: 'h000000, n: 3, w0: 'h000, w1: 'h000, w2: 'h080};
      vecs[4] = '{cnt: -10, low: 'h005555, n: 0, w0: 0,      w1: 0,      w2: 0};
      vecs[5] = '{cnt: 8,   low: 'hFFFFFF, n: 3, w0: 'h001, w1: 'h000, w2: 'h040};
      vecs[6] = '{cnt: -16, low: 'h000000, n: 0, w0: 0,      w1: 0,      w2: 0};

      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_cnt    = '0;
      bus.in_low    = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_word", bus.out_word, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_done", bus.done, 0);
`ifdef FINAL_FLUSH_STATS_EN
      check("rst_flush_words", bus.flush_words, 0);
`endif
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         exp_q.delete();
         if (vecs[i].n > 0) exp_q.push_back(vecs[i].w0);
         if (vecs[i].n > 1) exp_q.push_back(vecs[i].w1);
         if (vecs[i].n > 2) exp_q.push_back(vecs[i].w2);
         run_flush(vecs[i].cnt, vecs[i].low, 100, -1, 0);
      end

      // Backpressure: hold word index 1 for three cycles.
      exp_q.delete();
      exp_q.push_back('h000);
      exp_q.push_back('h000);
      exp_q.push_back('h080);
      run_flush(7, 0, 100, 1, 3);

      // Reset while word 2 of a three-word flush is presented.
      @(negedge clk);
      bus.in_cnt = 5'(7);
      bus.in_low = '0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      check("rst_seq_w0", bus.out_word, 'h000);
      @(negedge clk);
      hs_total++;
      check("rst_seq_w1_valid", bus.out_valid, 1);
      #2 reset = 1'b1;
      #1;
      hs_total = 0;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_out_word", bus.out_word, 0);
      check("mid_rst_out_last", bus.out_last, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
`ifdef FINAL_FLUSH_STATS_EN
      check("mid_rst_flush_words", bus.flush_words, 0);
`endif
      bus.out_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("post_rst_done", bus.done, 0);
         check("post_rst_out_valid", bus.out_valid, 0);
      end
      build_expected(0, 'h0ABCDE);
      run_flush(0, 'h0ABCDE, 100, -1, 0);

      for (int i = 0; i < 300; i++) begin
         int cnt;
         int low;
         cnt = int'($urandom_range(24)) - 16;
         low = int'($urandom & 32'h00FF_FFFF);
         if ($urandom_range(3) == 0) low = low | 'hFFC000;
         build_expected(cnt, longint'(low));
         run_flush(cnt, low, int'($urandom_range(100, 30)), -1, 0);
      end

`ifdef FINAL_FLUSH_STATS_EN
      check("flush_words_total", bus.flush_words, (hs_total > 255) ? 255 : hs_total);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
